// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Purpose  : Raster timing bundle between the timing source and the pixel
//            generators / VGA connector.
// Ports    : ce           count enable, driven by the consumer side
//            hcount[10:0] current pixel column
//            vcount[9:0]  current line
//            hsync/vsync  sync levels, polarity set by the generator
//            blank        1 outside the visible area
//            line_start   1-cycle pulse when hcount wraps to 0
//            frame_start  1-cycle pulse when (hcount,vcount) wraps to (0,0)
//            frame_count  frames completed since reset
//            pixel[23:0]  test-pattern RGB
// Modports : master = timing generator, slave = consumer
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  logic        ce;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;
  logic [23:0] pixel;

  modport master (
    input  ce,
    output hcount, vcount, hsync, vsync, blank,
    output line_start, frame_start, frame_count, pixel
  );

  modport slave (
    output ce,
    input  hcount, vcount, hsync, vsync, blank,
    input  line_start, frame_start, frame_count, pixel
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Video raster timing source. Produces hcount/vcount, sync levels,
//            blanking, line/frame pulses, a frame counter and an optional
//            colour-bar test pattern. Every output is registered and
//            describes the (hcount,vcount) presented in the same cycle.
// Ports    : clk      pixel clock
//            reset_n  asynchronous active-low reset; release is expected
//                     to be synchronous to clk
//            vif      vga_timing_gen_if.master (ce in, raster stream out)
// Options  : VGA_TIMING_TESTPAT_EN - when defined, pixel carries 8 vertical
//            colour bars; otherwise pixel is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  vga_timing_gen_if.master vif
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] c_H_LAST     = 11'(c_H_TOTAL - 1);
  localparam logic [10:0] c_H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  c_V_LAST     = 10'(c_V_TOTAL - 1);
  localparam logic [9:0]  c_V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  c_VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank;
  logic        r_line_start;
  logic        r_frame_start;
  logic [15:0] r_frame_count;
  logic [23:0] r_pixel;

  logic [10:0] w_h_next;
  logic [9:0]  w_v_next;
  logic        w_line_wrap;
  logic        w_frame_wrap;
  logic        w_hsync_act;
  logic        w_vsync_act;
  logic        w_blank_next;
  logic [23:0] w_pixel_next;

  // Next raster position; only meaningful when ce is high.
  always_comb begin
    w_h_next     = r_hcount + 11'd1;
    w_v_next     = r_vcount;
    w_line_wrap  = 1'b0;
    w_frame_wrap = 1'b0;
    if (r_hcount == c_H_LAST) begin
      w_h_next    = 11'd0;
      w_line_wrap = 1'b1;
      if (r_vcount == c_V_LAST) begin
        w_v_next     = 10'd0;
        w_frame_wrap = 1'b1;
      end else begin
        w_v_next = r_vcount + 10'd1;
      end
    end
  end

  // Levels are decoded from the next position so that, once registered,
  // they line up with the counters shown in the same cycle.
  always_comb begin
    w_hsync_act  = (w_h_next >= c_HS_START) && (w_h_next < c_HS_END);
    w_vsync_act  = (w_v_next >= c_VS_START) && (w_v_next < c_VS_END);
    w_blank_next = (w_h_next >= c_H_ACT) || (w_v_next >= c_V_ACT);
  end

`ifdef VGA_TIMING_TESTPAT_EN
  localparam int c_BAR_W = H_ACTIVE / 8;

  logic [10:0] w_bar_idx;

  always_comb begin
    w_bar_idx    = w_h_next / 11'(c_BAR_W);
    w_pixel_next = 24'h000000;
    if (!w_blank_next) begin
      case (w_bar_idx)
        11'd0:   w_pixel_next = 24'hFFFFFF;
        11'd1:   w_pixel_next = 24'hFFFF00;
        11'd2:   w_pixel_next = 24'h00FFFF;
        11'd3:   w_pixel_next = 24'h00FF00;
        11'd4:   w_pixel_next = 24'hFF00FF;
        11'd5:   w_pixel_next = 24'hFF0000;
        11'd6:   w_pixel_next = 24'h0000FF;
        default: w_pixel_next = 24'h000000;
      endcase
    end
  end
`else
  assign w_pixel_next = 24'h000000;
`endif

  // With ce low everything holds, including the levels latched at reset,
  // so a frozen raster never changes any output; only the pulses drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcount      <= 11'd0;
      r_vcount      <= 10'd0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 16'd0;
      r_pixel       <= 24'h000000;
    end else if (vif.ce) begin
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_hsync       <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
      r_blank       <= w_blank_next;
      r_line_start  <= w_line_wrap;
      r_frame_start <= w_frame_wrap;
      r_pixel       <= w_pixel_next;
      if (w_frame_wrap) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign vif.hcount      = r_hcount;
  assign vif.vcount      = r_vcount;
  assign vif.hsync       = r_hsync;
  assign vif.vsync       = r_vsync;
  assign vif.blank       = r_blank;
  assign vif.line_start  = r_line_start;
  assign vif.frame_start = r_frame_start;
  assign vif.frame_count = r_frame_count;
  assign vif.pixel       = r_pixel;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen. One instance uses the
//            default 1024x768 timing and is checked against a table of
//            line-position vectors; a second, reduced-size instance is run
//            for several frames against a cycle scoreboard fed by a small
//            raster model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef VGA_TIMING_TESTPAT_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  // Reduced raster for multi-frame runs: H_TOTAL 48, V_TOTAL 23.
  localparam int SH_A = 32, SH_F = 4, SH_S = 8, SH_B = 4;
  localparam int SV_A = 16, SV_F = 2, SV_S = 3, SV_B = 2;
  localparam int SH_T = SH_A + SH_F + SH_S + SH_B;
  localparam int SV_T = SV_A + SV_F + SV_S + SV_B;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vga_timing_gen_if dif ();
  vga_timing_gen_if sif ();

  vga_timing_gen u_dut_def (
    .clk     (clk),
    .reset_n (reset_n),
    .vif     (dif)
  );

  vga_timing_gen #(
    .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
    .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B),
    .SYNC_POL (1'b0)
  ) u_dut_small (
    .clk     (clk),
    .reset_n (reset_n),
    .vif     (sif)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
    logic [23:0] px;
  } obs_t;

  typedef struct {
    int          adv;
    int          h;
    int          v;
    bit          hs;
    bit          bl;
    bit          ls;
    logic [23:0] pix;
  } dvec_t;

  int   total = 0;
  int   bad   = 0;
  obs_t sb_q[$];

  // Raster model state for the reduced instance
  int          mh, mv;
  logic [15:0] mfc;
  bit          m_hs, m_vs, m_bl, m_ls, m_fs;
  logic [23:0] m_px;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] bar(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mfc = 16'd0;
    m_hs = 1'b1; m_vs = 1'b1; m_bl = 1'b0;
    m_ls = 1'b0; m_fs = 1'b0; m_px = 24'h0;
  endtask

  task automatic model_step(input bit c);
    m_ls = 1'b0;
    m_fs = 1'b0;
    if (c) begin
      if (mh == SH_T - 1) begin
        mh   = 0;
        m_ls = 1'b1;
        if (mv == SV_T - 1) begin
          mv   = 0;
          m_fs = 1'b1;
          mfc  = mfc + 16'd1;
        end else begin
          mv = mv + 1;
        end
      end else begin
        mh = mh + 1;
      end
      m_hs = !((mh >= SH_A + SH_F) && (mh < SH_A + SH_F + SH_S));
      m_vs = !((mv >= SV_A + SV_F) && (mv < SV_A + SV_F + SV_S));
      m_bl = (mh >= SH_A) || (mv >= SV_A);
      m_px = (TP && !m_bl) ? bar(mh / (SH_A / 8)) : 24'h0;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.h = 11'(mh); o.v = 10'(mv);
    o.hs = m_hs; o.vs = m_vs; o.bl = m_bl;
    o.ls = m_ls; o.fs = m_fs; o.fc = mfc; o.px = m_px;
    return o;
  endfunction

  function automatic obs_t grab_small();
    obs_t o;
    o.h = sif.hcount; o.v = sif.vcount;
    o.hs = sif.hsync; o.vs = sif.vsync; o.bl = sif.blank;
    o.ls = sif.line_start; o.fs = sif.frame_start;
    o.fc = sif.frame_count; o.px = sif.pixel;
    return o;
  endfunction

  // One clock on the reduced instance: expectation queued at drive time,
  // retired when the registered outputs appear after the edge.
  task automatic sstep(input bit c);
    obs_t e, a;
    sif.ce = c;
    model_step(c);
    sb_q.push_back(model_obs());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    a = grab_small();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL sb h=%0d v=%0d: got %h want %h", e.h, e.v, a, e);
    end
  endtask

  task automatic chk_small_reset(input string tag);
    chk({tag, ".h"},  32'(sif.hcount), 32'd0);
    chk({tag, ".v"},  32'(sif.vcount), 32'd0);
    chk({tag, ".hs"}, 32'(sif.hsync), 32'd1);
    chk({tag, ".vs"}, 32'(sif.vsync), 32'd1);
    chk({tag, ".bl"}, 32'(sif.blank), 32'd0);
    chk({tag, ".fs"}, 32'(sif.frame_start), 32'd0);
    chk({tag, ".ls"}, 32'(sif.line_start), 32'd0);
    chk({tag, ".fc"}, 32'(sif.frame_count), 32'd0);
    chk({tag, ".px"}, 32'(sif.pixel), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    dvec_t dtab[13];
    int    guard;

    // Default-timing line walk, cumulative from reset release.
    dtab[0]  = '{1,    1,    0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF};
    dtab[1]  = '{1,    2,    0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF};
    dtab[2]  = '{1,    3,    0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF};
    dtab[3]  = '{125,  128,  0, 1'b1, 1'b0, 1'b0, 24'hFFFF00};
    dtab[4]  = '{895,  1023, 0, 1'b1, 1'b0, 1'b0, 24'h000000};
    dtab[5]  = '{1,    1024, 0, 1'b1, 1'b1, 1'b0, 24'h000000};
    dtab[6]  = '{23,   1047, 0, 1'b1, 1'b1, 1'b0, 24'h000000};
    dtab[7]  = '{1,    1048, 0, 1'b0, 1'b1, 1'b0, 24'h000000};
    dtab[8]  = '{135,  1183, 0, 1'b0, 1'b1, 1'b0, 24'h000000};
    dtab[9]  = '{1,    1184, 0, 1'b1, 1'b1, 1'b0, 24'h000000};
    dtab[10] = '{159,  1343, 0, 1'b1, 1'b1, 1'b0, 24'h000000};
    dtab[11] = '{1,    0,    1, 1'b1, 1'b0, 1'b1, 24'hFFFFFF};
    dtab[12] = '{1,    1,    1, 1'b1, 1'b0, 1'b0, 24'hFFFFFF};

    reset_n = 1'b0;
    dif.ce  = 1'b0;
    sif.ce  = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("rst.h",  32'(dif.hcount), 32'd0);
    chk("rst.v",  32'(dif.vcount), 32'd0);
    chk("rst.hs", 32'(dif.hsync), 32'd1);
    chk("rst.vs", 32'(dif.vsync), 32'd1);
    chk("rst.bl", 32'(dif.blank), 32'd0);
    chk("rst.fc", 32'(dif.frame_count), 32'd0);
    chk("rst.px", 32'(dif.pixel), 32'd0);
    chk_small_reset("rst_s");

    reset_n = 1'b1;
    dif.ce  = 1'b1;
    for (int i = 0; i < 13; i++) begin
      repeat (dtab[i].adv) @(posedge clk);
      #1;
      chk($sformatf("tab%0d.h", i),  32'(dif.hcount), 32'(dtab[i].h));
      chk($sformatf("tab%0d.v", i),  32'(dif.vcount), 32'(dtab[i].v));
      chk($sformatf("tab%0d.hs", i), 32'(dif.hsync), 32'(dtab[i].hs));
      chk($sformatf("tab%0d.bl", i), 32'(dif.blank), 32'(dtab[i].bl));
      chk($sformatf("tab%0d.ls", i), 32'(dif.line_start), 32'(dtab[i].ls));
      chk($sformatf("tab%0d.px", i), 32'(dif.pixel), TP ? 32'(dtab[i].pix) : 32'd0);
    end

    // Freeze at hcount=500 for 10 clocks, then resume.
    repeat (499) @(posedge clk);
    #1;
    chk("frz.h0", 32'(dif.hcount), 32'd500);
    dif.ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("frz%0d.h", i),  32'(dif.hcount), 32'd500);
      chk($sformatf("frz%0d.v", i),  32'(dif.vcount), 32'd1);
      chk($sformatf("frz%0d.ls", i), 32'(dif.line_start), 32'd0);
      chk($sformatf("frz%0d.px", i), 32'(dif.pixel), TP ? 32'h00FF00 : 32'd0);
    end
    dif.ce = 1'b1;
    @(posedge clk);
    #1;
    chk("frz.resume", 32'(dif.hcount), 32'd501);
    dif.ce = 1'b0;

    // Reduced instance: held since reset, then three frames with ce gaps.
    repeat (3) sstep(1'b0);
    guard = 0;
    while (!(mfc == 16'd3 && mh == 5) && guard < 20000) begin
      sstep($urandom_range(0, 9) != 0);
      guard++;
    end
    chk("frames.fc", 32'(sif.frame_count), 32'd3);

    guard = 0;
    while (!(mv == 10 && mh == 30) && guard < 5000) begin
      sstep(1'b1);
      guard++;
    end
    chk("mid.h", 32'(sif.hcount), 32'd30);

    // Asynchronous clear away from the clock edge, then restart.
    #2;
    reset_n = 1'b0;
    #1;
    chk_small_reset("arst");
    @(posedge clk);
    #1;
    chk_small_reset("arst_hold");
    model_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) sstep(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
